// File: rtl/frame_ram_arbiter_if.sv
// Requester, RAM and (with FRAME_RAM_ARB_STATS_EN) statistics signals of frame_ram_arbiter.
// The arbiter uses the slave modport; the requester/RAM side uses master.
interface frame_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 24
);
    logic                  disp_req_in;
    logic [ADDR_WIDTH-1:0] disp_addr_in;
    logic                  disp_gnt_out;
    logic [DATA_WIDTH-1:0] disp_data_out;
    logic                  disp_valid_out;

    logic                  host_req_in;
    logic                  host_we_in;
    logic [ADDR_WIDTH-1:0] host_addr_in;
    logic [DATA_WIDTH-1:0] host_data_in;
    logic                  host_gnt_out;
    logic [DATA_WIDTH-1:0] host_data_out;
    logic                  host_valid_out;

    logic                  ram_enable_out;
    logic                  ram_write_enable_out;
    logic [ADDR_WIDTH-1:0] ram_addr_out;
    logic [DATA_WIDTH-1:0] ram_wdata_out;
    logic [DATA_WIDTH-1:0] ram_rdata_in;

`ifdef FRAME_RAM_ARB_STATS_EN
    logic [15:0]           conflict_count_out;
    logic [15:0]           starve_hit_count_out;
`endif

    modport slave (
`ifdef FRAME_RAM_ARB_STATS_EN
        output conflict_count_out, starve_hit_count_out,
`endif
        input  disp_req_in, disp_addr_in,
        output disp_gnt_out, disp_data_out, disp_valid_out,
        input  host_req_in, host_we_in, host_addr_in, host_data_in,
        output host_gnt_out, host_data_out, host_valid_out,
        output ram_enable_out, ram_write_enable_out, ram_addr_out, ram_wdata_out,
        input  ram_rdata_in
    );

    modport master (
`ifdef FRAME_RAM_ARB_STATS_EN
        input  conflict_count_out, starve_hit_count_out,
`endif
        output disp_req_in, disp_addr_in,
        input  disp_gnt_out, disp_data_out, disp_valid_out,
        output host_req_in, host_we_in, host_addr_in, host_data_in,
        input  host_gnt_out, host_data_out, host_valid_out,
        input  ram_enable_out, ram_write_enable_out, ram_addr_out, ram_wdata_out,
        output ram_rdata_in
    );
endinterface

// File: rtl/frame_ram_arbiter.sv
// Single-port frame RAM arbiter: display reads win unless the host has waited WR_STARVE_MAX grants.
// Define FRAME_RAM_ARB_STATS_EN to add conflict and starvation-hit counters.
module frame_ram_arbiter #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 24,
    parameter int RD_LATENCY    = 1,
    parameter int WR_STARVE_MAX = 8
) (
    input  logic               clk_in,
    input  logic               n_reset_in,
    frame_ram_arbiter_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(WR_STARVE_MAX + 1);
    localparam int TAG_DEPTH = RD_LATENCY + 1;
    localparam logic [CNT_WIDTH-1:0] STARVE_LIMIT = CNT_WIDTH'(WR_STARVE_MAX);
    localparam logic OWNER_DISP = 1'b0;
    localparam logic OWNER_HOST = 1'b1;

    logic [CNT_WIDTH-1:0]  starve_cnt_reg, starve_cnt_next;
    logic                  host_forced;
    logic                  disp_gnt, host_gnt;
    logic                  rd_xfer;

    logic                  ram_en_reg, ram_we_reg;
    logic [ADDR_WIDTH-1:0] ram_addr_reg;
    logic [DATA_WIDTH-1:0] ram_wdata_reg;

    logic [TAG_DEPTH-1:0]  tag_valid_reg, tag_owner_reg;
    logic                  ret_disp, ret_host;
    logic                  disp_valid_reg, host_valid_reg;
    logic [DATA_WIDTH-1:0] disp_data_reg, host_data_reg;

    // Grants depend only on requests and the starve counter, never on address or data.
    assign host_forced = bus.disp_req_in && bus.host_req_in && (starve_cnt_reg == STARVE_LIMIT);
    assign disp_gnt    = n_reset_in && bus.disp_req_in && !host_forced;
    assign host_gnt    = n_reset_in && bus.host_req_in && (!bus.disp_req_in || host_forced);
    assign rd_xfer     = disp_gnt || (host_gnt && !bus.host_we_in);

    assign bus.disp_gnt_out = disp_gnt;
    assign bus.host_gnt_out = host_gnt;

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!bus.host_req_in || host_gnt) begin
            starve_cnt_next = '0;
        end else if (disp_gnt && (starve_cnt_reg != STARVE_LIMIT)) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!n_reset_in) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Address and write data hold between commands; only enable and write enable drop.
    always_ff @(posedge clk_in) begin
        if (!n_reset_in) begin
            ram_en_reg    <= 1'b0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
        end else if (host_gnt) begin
            ram_en_reg    <= 1'b1;
            ram_we_reg    <= bus.host_we_in;
            ram_addr_reg  <= bus.host_addr_in;
            ram_wdata_reg <= bus.host_we_in ? bus.host_data_in : '0;
        end else if (disp_gnt) begin
            ram_en_reg    <= 1'b1;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= bus.disp_addr_in;
            ram_wdata_reg <= '0;
        end else begin
            ram_en_reg    <= 1'b0;
            ram_we_reg    <= 1'b0;
        end
    end

    assign bus.ram_enable_out       = ram_en_reg;
    assign bus.ram_write_enable_out = ram_we_reg;
    assign bus.ram_addr_out         = ram_addr_reg;
    assign bus.ram_wdata_out        = ram_wdata_reg;

    // Stage 0 is loaded at the transfer edge; stage RD_LATENCY lines up with valid RAM data.
    always_ff @(posedge clk_in) begin
        if (!n_reset_in) begin
            tag_valid_reg[0] <= 1'b0;
            tag_owner_reg[0] <= OWNER_DISP;
        end else begin
            tag_valid_reg[0] <= rd_xfer;
            tag_owner_reg[0] <= host_gnt ? OWNER_HOST : OWNER_DISP;
        end
    end

    generate
        for (genvar gi = 1; gi < TAG_DEPTH; gi++) begin : g_tag
            always_ff @(posedge clk_in) begin
                if (!n_reset_in) begin
                    tag_valid_reg[gi] <= 1'b0;
                    tag_owner_reg[gi] <= OWNER_DISP;
                end else begin
                    tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                    tag_owner_reg[gi] <= tag_owner_reg[gi-1];
                end
            end
        end
    endgenerate

    assign ret_disp = tag_valid_reg[RD_LATENCY] && (tag_owner_reg[RD_LATENCY] == OWNER_DISP);
    assign ret_host = tag_valid_reg[RD_LATENCY] && (tag_owner_reg[RD_LATENCY] == OWNER_HOST);

    always_ff @(posedge clk_in) begin
        if (!n_reset_in) begin
            disp_valid_reg <= 1'b0;
            host_valid_reg <= 1'b0;
            disp_data_reg  <= '0;
            host_data_reg  <= '0;
        end else begin
            disp_valid_reg <= ret_disp;
            host_valid_reg <= ret_host;
            if (ret_disp) begin
                disp_data_reg <= bus.ram_rdata_in;
            end
            if (ret_host) begin
                host_data_reg <= bus.ram_rdata_in;
            end
        end
    end

    assign bus.disp_valid_out = disp_valid_reg;
    assign bus.disp_data_out  = disp_data_reg;
    assign bus.host_valid_out = host_valid_reg;
    assign bus.host_data_out  = host_data_reg;

`ifdef FRAME_RAM_ARB_STATS_EN
    logic [15:0] conflict_cnt_reg, starve_hit_cnt_reg;

    always_ff @(posedge clk_in) begin
        if (!n_reset_in) begin
            conflict_cnt_reg   <= '0;
            starve_hit_cnt_reg <= '0;
        end else begin
            if (bus.disp_req_in && bus.host_req_in && (conflict_cnt_reg != 16'hFFFF)) begin
                conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
            end
            if (host_forced && (starve_hit_cnt_reg != 16'hFFFF)) begin
                starve_hit_cnt_reg <= starve_hit_cnt_reg + 16'd1;
            end
        end
    end

    assign bus.conflict_count_out   = conflict_cnt_reg;
    assign bus.starve_hit_count_out = starve_hit_cnt_reg;
`endif
endmodule
